// File: rtl/rc4_encrypt_core.sv
// RC4 reference encryptor: init, KSA and PRGA over an external S RAM, writing pt ^ keystream to a ciphertext RAM.
// Latency: fixed per run, 256 + 6*256 + 9*MSG_LEN + 1 cycles from an accepted start to the done pulse.
// Backpressure: none; RAMs are assumed always ready, and a start is only sampled while idle.
//
// Ports:
//   clk, reset            : clock and synchronous active-high reset
//   start, key_in         : one-cycle run request with its key (MSB byte is key byte 0)
//   busy, done            : run in progress / one-cycle completion pulse
//   s_addr/s_wdata/s_wren : S RAM port, s_rdata valid one cycle after s_addr
//   pt_addr/pt_rdata      : plaintext ROM port, pt_rdata valid one cycle after pt_addr
//   ct_addr/ct_wdata/ct_wren : ciphertext RAM write port
module rc4_encrypt_core #(
  parameter int MSG_LEN = 32,
  parameter int KEY_LEN = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [8*KEY_LEN-1:0] key_in,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           s_addr,
  output logic [7:0]           s_wdata,
  output logic                 s_wren,
  input  logic [7:0]           s_rdata,
  output logic [4:0]           pt_addr,
  input  logic [7:0]           pt_rdata,
  output logic [4:0]           ct_addr,
  output logic [7:0]           ct_wdata,
  output logic                 ct_wren
);

  localparam logic [4:0] K_LAST   = 5'(MSG_LEN - 1);
  localparam logic [7:0] KIDX_LAST = 8'(KEY_LEN - 1);

  // Each read takes three states: present address, wait for the RAM register, capture.
  typedef enum logic [4:0] {
    ST_IDLE, ST_INIT,
    ST_K_RDI, ST_K_WI, ST_K_GI, ST_K_WJ, ST_K_GJ, ST_K_SWJ,
    ST_P_RDI, ST_P_WI, ST_P_GI, ST_P_WJ, ST_P_GJ, ST_P_SWJ,
    ST_P_RDF, ST_P_WF, ST_P_GF, ST_DONE
  } state_t;

  state_t state_q, state_d;
  logic [7:0] i_q, i_d, j_q, j_d, si_q, si_d, sj_q, sj_d, kidx_q, kidx_d;
  logic [4:0] k_q, k_d;
  logic [8*KEY_LEN-1:0] key_q, key_d;
  logic busy_q, busy_d, done_q, done_d, s_wren_q, s_wren_d, ct_wren_q, ct_wren_d;
  logic [7:0] s_addr_q, s_addr_d, s_wdata_q, s_wdata_d, ct_wdata_q, ct_wdata_d;
  logic [4:0] pt_addr_q, pt_addr_d, ct_addr_q, ct_addr_d;
  logic [7:0] key_byte, i_inc, j_ksa, j_prga;

  // Key byte i mod KEY_LEN, tracked by a wrapping counter instead of a divider.
  always_comb begin
    key_byte = 8'd0;
    for (int n = 0; n < KEY_LEN; n++) begin
      if (kidx_q == 8'(n)) key_byte = key_q[8*(KEY_LEN-1-n) +: 8];
    end
  end

  assign i_inc  = i_q + 8'd1;
  assign j_ksa  = j_q + s_rdata + key_byte;
  assign j_prga = j_q + s_rdata;

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    k_d        = k_q;
    kidx_d     = kidx_q;
    si_d       = si_q;
    sj_d       = sj_q;
    key_d      = key_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    s_wren_d   = 1'b0;
    ct_wren_d  = 1'b0;
    s_addr_d   = s_addr_q;
    s_wdata_d  = s_wdata_q;
    pt_addr_d  = pt_addr_q;
    ct_addr_d  = ct_addr_q;
    ct_wdata_d = ct_wdata_q;
    unique case (state_q)
      ST_IDLE: if (start) begin
        key_d   = key_in;
        i_d     = 8'd0;
        j_d     = 8'd0;
        k_d     = 5'd0;
        kidx_d  = 8'd0;
        busy_d  = 1'b1;
        state_d = ST_INIT;
      end
      ST_INIT: begin
        s_addr_d  = i_q;
        s_wdata_d = i_q;
        s_wren_d  = 1'b1;
        i_d       = i_inc;
        if (i_q == 8'd255) state_d = ST_K_RDI;
      end
      ST_K_RDI: begin
        s_addr_d = i_q;
        state_d  = ST_K_WI;
      end
      ST_K_WI: state_d = ST_K_GI;
      ST_K_GI: begin
        si_d     = s_rdata;
        j_d      = j_ksa;
        s_addr_d = j_ksa;
        state_d  = ST_K_WJ;
      end
      ST_K_WJ: state_d = ST_K_GJ;
      ST_K_GJ: begin
        sj_d      = s_rdata;
        s_addr_d  = i_q;
        s_wdata_d = s_rdata;
        s_wren_d  = 1'b1;
        state_d   = ST_K_SWJ;
      end
      ST_K_SWJ: begin
        // Second swap write goes out next cycle, overlapping the next address setup.
        s_addr_d  = j_q;
        s_wdata_d = si_q;
        s_wren_d  = 1'b1;
        i_d       = i_inc;
        kidx_d    = (kidx_q == KIDX_LAST) ? 8'd0 : kidx_q + 8'd1;
        if (i_q == 8'd255) begin
          j_d     = 8'd0;
          state_d = ST_P_RDI;
        end else begin
          state_d = ST_K_RDI;
        end
      end
      ST_P_RDI: begin
        i_d      = i_inc;
        s_addr_d = i_inc;
        state_d  = ST_P_WI;
      end
      ST_P_WI: state_d = ST_P_GI;
      ST_P_GI: begin
        si_d     = s_rdata;
        j_d      = j_prga;
        s_addr_d = j_prga;
        state_d  = ST_P_WJ;
      end
      ST_P_WJ: state_d = ST_P_GJ;
      ST_P_GJ: begin
        sj_d      = s_rdata;
        s_addr_d  = i_q;
        s_wdata_d = s_rdata;
        s_wren_d  = 1'b1;
        state_d   = ST_P_SWJ;
      end
      ST_P_SWJ: begin
        s_addr_d  = j_q;
        s_wdata_d = si_q;
        s_wren_d  = 1'b1;
        state_d   = ST_P_RDF;
      end
      ST_P_RDF: begin
        // si+sj is swap-invariant, so this reads the standard keystream byte.
        s_addr_d  = si_q + sj_q;
        pt_addr_d = k_q;
        state_d   = ST_P_WF;
      end
      ST_P_WF: state_d = ST_P_GF;
      ST_P_GF: begin
        ct_addr_d  = k_q;
        ct_wdata_d = s_rdata ^ pt_rdata;
        ct_wren_d  = 1'b1;
        k_d        = k_q + 5'd1;
        state_d    = (k_q == K_LAST) ? ST_DONE : ST_P_RDI;
      end
      ST_DONE: begin
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      i_q        <= 8'd0;
      j_q        <= 8'd0;
      k_q        <= 5'd0;
      kidx_q     <= 8'd0;
      si_q       <= 8'd0;
      sj_q       <= 8'd0;
      key_q      <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      s_wren_q   <= 1'b0;
      ct_wren_q  <= 1'b0;
      s_addr_q   <= 8'd0;
      s_wdata_q  <= 8'd0;
      pt_addr_q  <= 5'd0;
      ct_addr_q  <= 5'd0;
      ct_wdata_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      i_q        <= i_d;
      j_q        <= j_d;
      k_q        <= k_d;
      kidx_q     <= kidx_d;
      si_q       <= si_d;
      sj_q       <= sj_d;
      key_q      <= key_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      s_wren_q   <= s_wren_d;
      ct_wren_q  <= ct_wren_d;
      s_addr_q   <= s_addr_d;
      s_wdata_q  <= s_wdata_d;
      pt_addr_q  <= pt_addr_d;
      ct_addr_q  <= ct_addr_d;
      ct_wdata_q <= ct_wdata_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign s_addr   = s_addr_q;
  assign s_wdata  = s_wdata_q;
  assign s_wren   = s_wren_q;
  assign pt_addr  = pt_addr_q;
  assign ct_addr  = ct_addr_q;
  assign ct_wdata = ct_wdata_q;
  assign ct_wren  = ct_wren_q;

endmodule

// File: tb/tb_rc4_encrypt_core.sv
// Directed bench for rc4_encrypt_core with behavioural S RAM, plaintext ROM and ciphertext RAM.
// Latency: checks run length against the allowed bound and against a clean reference run.
// Backpressure: none; memories respond one cycle after the address.
module tb_rc4_encrypt_core;

  localparam int MSG_LEN = 32;
  localparam int BOUND   = 256 + 256*7 + MSG_LEN*12 + 4;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [23:0] key_in;
  logic        busy, done, s_wren, ct_wren;
  logic [7:0]  s_addr, s_wdata, s_rdata, pt_rdata, ct_wdata;
  logic [4:0]  pt_addr, ct_addr;

  logic [7:0] s_mem  [256];
  logic [7:0] pt_mem [32];
  logic [7:0] ct_mem [32];

  int n_chk = 0;
  int n_pass = 0;
  int ct_cnt = 0, s_wr_cnt = 0, s_bad = 0, done_cnt = 0;

  rc4_encrypt_core #(.MSG_LEN(MSG_LEN), .KEY_LEN(3)) dut (
    .clk(clk), .reset(reset), .start(start), .key_in(key_in),
    .busy(busy), .done(done),
    .s_addr(s_addr), .s_wdata(s_wdata), .s_wren(s_wren), .s_rdata(s_rdata),
    .pt_addr(pt_addr), .pt_rdata(pt_rdata),
    .ct_addr(ct_addr), .ct_wdata(ct_wdata), .ct_wren(ct_wren)
  );

  always #5 clk = ~clk;

  // Memory models and protocol monitors.
  always @(posedge clk) begin
    if (s_wren) s_mem[s_addr] <= s_wdata;
    s_rdata  <= s_mem[s_addr];
    pt_rdata <= pt_mem[pt_addr];
    if (ct_wren) begin
      ct_mem[ct_addr] <= ct_wdata;
      ct_cnt <= ct_cnt + 1;
    end
    if (s_wren) s_wr_cnt <= s_wr_cnt + 1;
    if (s_wren && !busy) s_bad <= s_bad + 1;
    if (done) done_cnt <= done_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Starts a run at the current negedge; optionally pulses a stray start or a reset mid-run.
  // Returns at the negedge where done is visible (or right after the reset took effect).
  task automatic run_core(input logic [23:0] key, input int inj_start_at, input int rst_at,
                          output int cycles);
    int  ct_base;
    bit  aborted;
    ct_base = ct_cnt;
    aborted = 0;
    start   = 1'b1;
    key_in  = key;
    @(negedge clk);
    start  = 1'b0;
    cycles = 1;
    while (!done && !aborted && cycles < 3000) begin
      if (cycles == inj_start_at) begin
        start  = 1'b1;
        key_in = 24'hFFFFFF;
      end
      if (cycles == rst_at) begin
        reset   = 1'b1;
        aborted = 1;
      end
      @(negedge clk);
      start = 1'b0;
      reset = 1'b0;
      cycles++;
    end
    if (aborted) begin
      chk("abort_busy", {31'd0, busy}, 32'd0);
      chk("abort_swren", {31'd0, s_wren}, 32'd0);
      chk("abort_ctwren", {31'd0, ct_wren}, 32'd0);
    end else begin
      chk("done_seen", {31'd0, done}, 32'd1);
      chk("busy_at_done", {31'd0, busy}, 32'd0);
      chk("ct_wr_count", 32'(ct_cnt - ct_base), 32'(MSG_LEN));
      chk("within_bound", {31'd0, cycles <= BOUND}, 32'd1);
    end
  endtask

  logic [7:0] exp_ct [10] = '{8'hBB, 8'hF3, 8'h16, 8'hE8, 8'hD9, 8'h40, 8'hAF, 8'h0A, 8'hD3, 8'h19};
  logic [7:0] exp_ks [10] = '{8'hEB, 8'h9F, 8'h77, 8'h81, 8'hB7, 8'h34, 8'hCA, 8'h72, 8'hA7, 8'h19};
  logic [7:0] ptxt   [9]  = '{8'h50, 8'h6C, 8'h61, 8'h69, 8'h6E, 8'h74, 8'h65, 8'h78, 8'h74};
  logic [7:0] saved_ct [9];

  initial begin
    int cyc_clean, cyc_tmp, wr_base, ct_base, done_base;
    reset  = 1'b1;
    start  = 1'b0;
    key_in = 24'd0;
    for (int a = 0; a < 256; a++) s_mem[a] = 8'd0;
    for (int a = 0; a < 32; a++) begin
      pt_mem[a] = 8'd0;
      ct_mem[a] = 8'd0;
    end
    for (int a = 0; a < 9; a++) pt_mem[a] = ptxt[a];
    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state and quiet idle.
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_swren", {31'd0, s_wren}, 32'd0);
    chk("rst_ctwren", {31'd0, ct_wren}, 32'd0);
    chk("rst_saddr", {24'd0, s_addr}, 32'd0);
    chk("rst_ctaddr", {27'd0, ct_addr}, 32'd0);
    wr_base = s_wr_cnt;
    ct_base = ct_cnt;
    repeat (100) @(negedge clk);
    chk("idle_s_writes", 32'(s_wr_cnt - wr_base), 32'd0);
    chk("idle_ct_writes", 32'(ct_cnt - ct_base), 32'd0);

    // Reset and start together: reset wins.
    reset  = 1'b1;
    start  = 1'b1;
    key_in = 24'h4B6579;
    @(negedge clk);
    reset = 1'b0;
    start = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_start_busy", {31'd0, busy}, 32'd0);
    chk("rst_start_writes", 32'(s_wr_cnt - wr_base), 32'd0);

    // "Plaintext" under key "Key".
    done_base = done_cnt;
    run_core(24'h4B6579, -1, -1, cyc_clean);
    for (int k = 0; k < 10; k++) chk($sformatf("pt_ct%0d", k), {24'd0, ct_mem[k]}, {24'd0, exp_ct[k]});
    for (int k = 0; k < 9; k++) saved_ct[k] = ct_mem[k];

    // Back-to-back start on the done cycle, zero plaintext, stray start mid-KSA.
    for (int a = 0; a < 32; a++) pt_mem[a] = 8'd0;
    run_core(24'h4B6579, 600, -1, cyc_tmp);
    for (int k = 0; k < 10; k++) chk($sformatf("ks_ct%0d", k), {24'd0, ct_mem[k]}, {24'd0, exp_ks[k]});
    chk("b2b_cycles", 32'(cyc_tmp), 32'(cyc_clean));
    @(negedge clk);
    chk("done_one_cycle", {31'd0, done}, 32'd0);
    chk("busy_after", {31'd0, busy}, 32'd0);
    chk("done_pulses", 32'(done_cnt - done_base), 32'd2);

    // Reset during PRGA (k=5), then a clean run.
    for (int a = 0; a < 32; a++) ct_mem[a] = 8'd0;
    run_core(24'h4B6579, -1, 1840, cyc_tmp);
    chk("abort_no_done", 32'(done_cnt - done_base), 32'd2);
    @(negedge clk);
    run_core(24'h4B6579, -1, -1, cyc_tmp);
    for (int k = 0; k < 10; k++) chk($sformatf("rr_ct%0d", k), {24'd0, ct_mem[k]}, {24'd0, exp_ks[k]});
    chk("rr_cycles", 32'(cyc_tmp), 32'(cyc_clean));

    // Round trip: ciphertext back in as plaintext.
    @(negedge clk);
    for (int a = 0; a < 9; a++) pt_mem[a] = saved_ct[a];
    run_core(24'h4B6579, -1, -1, cyc_tmp);
    for (int k = 0; k < 9; k++) chk($sformatf("rt_pt%0d", k), {24'd0, ct_mem[k]}, {24'd0, ptxt[k]});

    @(negedge clk);
    chk("s_write_outside_run", 32'(s_bad), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
